// File: rtl/audio_transport_ctrl.sv
// Transport controller for the recorder/player datapath.
// Turns debounced key pulses into record/play/pause/stop sequencing, owns the
// SRAM sample address and recorded length, and drives the playback clock
// generator configuration (ratio, isNormalSpeed, interp, pause, isRecord).
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE       0 | stopped; codec clock held; rec_len holds last recording
// REC        1 | writing one sample per tick at addr, addr advancing
// REC_PAUSE  2 | recording suspended, addr kept for resume
// PLAY       3 | reading samples, addr stepped by the speed setting
// PLAY_PAUSE 4 | playback suspended, addr and repeat count kept
module audio_transport_ctrl #(
   parameter int ADDR_W  = 20,
   parameter int MAX_MAG = 8
) (
   input  logic              clk50,
   input  logic              reset,
   input  logic              key_record,
   input  logic              key_play,
   input  logic              key_pause,
   input  logic              key_stop,
   input  logic              key_faster,
   input  logic              key_slower,
   input  logic              key_interp,
   input  logic              sample_tick,
   output logic [ADDR_W-1:0] addr,
   output logic              sram_we,
   output logic [ADDR_W:0]   rec_len,
   output logic [2:0]        state,
   output logic [2:0]        ratio,
   output logic              isNormalSpeed,
   output logic              interp,
   output logic              pause,
   output logic              isRecord
);

   localparam int MAG_W = $clog2(MAX_MAG + 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_REC        = 3'd1,
      ST_REC_PAUSE  = 3'd2,
      ST_PLAY       = 3'd3,
      ST_PLAY_PAUSE = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rec_len_q, rec_len_d;
   logic [MAG_W-1:0]  rep_cnt_q, rep_cnt_d;
   logic [MAG_W-1:0]  mag_q, mag_d;
   logic              is_fast_q, is_fast_d;
   logic              interp_q, interp_d;

   logic              slow_q;
   logic              act_stop, act_rec, act_play, act_pause, key_act;
   logic              speed_ok, speed_chg;
   logic [ADDR_W:0]   step_v, next_addr;
   logic [MAG_W-1:0]  rep_next;

   assign slow_q = ~is_fast_q & (mag_q > MAG_W'(1));

   // Pick the single highest-priority transport key that applies in this state.
   always_comb begin
      act_stop  = key_stop & (state_q != ST_IDLE);
      act_rec   = key_record & ~act_stop &
                  ((state_q == ST_IDLE) | (state_q == ST_REC_PAUSE));
      act_play  = key_play & ~act_stop & ~act_rec &
                  (((state_q == ST_IDLE) & (rec_len_q != '0)) | (state_q == ST_PLAY_PAUSE));
      act_pause = key_pause & ~act_stop & ~act_rec & ~act_play & (state_q != ST_IDLE);
      key_act   = act_stop | act_rec | act_play | act_pause;
   end

   // Speed ladder: slow MAX..2 <-> normal <-> fast 2..MAX, saturating at both ends.
   always_comb begin
      is_fast_d = is_fast_q;
      mag_d     = mag_q;
      speed_ok  = ((state_q == ST_IDLE) | (state_q == ST_PLAY) | (state_q == ST_PLAY_PAUSE)) &
                  (key_faster ^ key_slower);
      if (speed_ok && key_faster) begin
         if (slow_q) begin
            mag_d = (mag_q > MAG_W'(2)) ? mag_q - MAG_W'(1) : MAG_W'(1);
         end else if (!is_fast_q) begin
            is_fast_d = 1'b1;
            mag_d     = MAG_W'(2);
         end else if (mag_q < MAG_W'(MAX_MAG)) begin
            mag_d = mag_q + MAG_W'(1);
         end
      end else if (speed_ok && key_slower) begin
         if (is_fast_q) begin
            if (mag_q > MAG_W'(2)) begin
               mag_d = mag_q - MAG_W'(1);
            end else begin
               is_fast_d = 1'b0;
               mag_d     = MAG_W'(1);
            end
         end else if (mag_q < MAG_W'(MAX_MAG)) begin
            mag_d = mag_q + MAG_W'(1);
         end
      end
      speed_chg = (is_fast_d != is_fast_q) | (mag_d != mag_q);
   end

   // Playback step for one tick: fast skips, slow repeats each sample mag times.
   always_comb begin
      step_v   = '0;
      rep_next = rep_cnt_q;
      if (is_fast_q) begin
         step_v = (ADDR_W+1)'(mag_q);
      end else if (slow_q) begin
         if (rep_cnt_q == mag_q - MAG_W'(1)) begin
            step_v   = (ADDR_W+1)'(1);
            rep_next = '0;
         end else begin
            rep_next = rep_cnt_q + MAG_W'(1);
         end
      end else begin
         step_v = (ADDR_W+1)'(1);
      end
      next_addr = {1'b0, addr_q} + step_v;
   end

   // Transport next-state and address/length update; keys pre-empt the tick.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rec_len_d = rec_len_q;
      rep_cnt_d = rep_cnt_q;
      interp_d  = interp_q ^ key_interp;
      case (state_q)
         ST_IDLE: begin
            if (act_rec) begin
               state_d   = ST_REC;
               addr_d    = '0;
               rec_len_d = '0;
            end else if (act_play) begin
               state_d   = ST_PLAY;
               addr_d    = '0;
               rep_cnt_d = '0;
            end
         end
         ST_REC: begin
            if (act_stop) begin
               state_d   = ST_IDLE;
               rec_len_d = {1'b0, addr_q};
               addr_d    = '0;
            end else if (act_pause) begin
               state_d = ST_REC_PAUSE;
            end else if (sample_tick) begin
               if (addr_q == {ADDR_W{1'b1}}) begin
                  state_d   = ST_IDLE;
                  rec_len_d = {1'b1, {ADDR_W{1'b0}}};
                  addr_d    = '0;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         ST_REC_PAUSE: begin
            if (act_stop) begin
               state_d   = ST_IDLE;
               rec_len_d = {1'b0, addr_q};
               addr_d    = '0;
            end else if (act_rec || act_pause) begin
               state_d = ST_REC;
            end
         end
         ST_PLAY: begin
            if (act_stop) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end else if (act_pause) begin
               state_d = ST_PLAY_PAUSE;
            end else if (sample_tick) begin
               if (next_addr >= rec_len_q) begin
                  state_d   = ST_IDLE;
                  addr_d    = '0;
                  rep_cnt_d = '0;
               end else begin
                  addr_d    = next_addr[ADDR_W-1:0];
                  rep_cnt_d = rep_next;
               end
            end
         end
         ST_PLAY_PAUSE: begin
            if (act_stop) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end else if (act_play || act_pause) begin
               state_d = ST_PLAY;
            end
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
      endcase
      if (speed_chg) begin
         rep_cnt_d = '0;
      end
   end

   // State and datapath registers; reset returns to idle at normal speed.
   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rec_len_q <= '0;
         rep_cnt_q <= '0;
         mag_q     <= MAG_W'(1);
         is_fast_q <= 1'b0;
         interp_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rec_len_q <= rec_len_d;
         rep_cnt_q <= rep_cnt_d;
         mag_q     <= mag_d;
         is_fast_q <= is_fast_d;
         interp_q  <= interp_d;
      end
   end

   // Output decode from registered state; the write strobe is blocked during reset.
   always_comb begin
      addr          = addr_q;
      rec_len       = rec_len_q;
      state         = state_q;
      interp        = interp_q;
      sram_we       = ~reset & (state_q == ST_REC) & sample_tick & ~key_act;
      ratio         = slow_q ? 3'(mag_q - MAG_W'(1)) : 3'd0;
      isNormalSpeed = ~slow_q;
      pause         = (state_q == ST_IDLE) | (state_q == ST_REC_PAUSE) |
                      (state_q == ST_PLAY_PAUSE);
      isRecord      = (state_q == ST_REC) | (state_q == ST_REC_PAUSE);
   end

endmodule

// File: tb/tb_audio_transport_ctrl.sv
// Bench for audio_transport_ctrl: directed scenarios followed by random key and
// tick traffic, all checked each cycle against a behavioural model that keeps
// speed as one signed setting (+n fast, -n slow, 0 normal).
module tb_audio_transport_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int MAXM  = 8;

   localparam bit [6:0] K_REC  = 7'b0000001;
   localparam bit [6:0] K_PLAY = 7'b0000010;
   localparam bit [6:0] K_PAUS = 7'b0000100;
   localparam bit [6:0] K_STOP = 7'b0001000;
   localparam bit [6:0] K_FAST = 7'b0010000;
   localparam bit [6:0] K_SLOW = 7'b0100000;
   localparam bit [6:0] K_INT  = 7'b1000000;

   localparam int M_IDLE = 0, M_REC = 1, M_RP = 2, M_PLAY = 3, M_PP = 4;

   logic          clk50 = 1'b0;
   logic          reset;
   logic          key_record, key_play, key_pause, key_stop;
   logic          key_faster, key_slower, key_interp, sample_tick;
   logic [AW-1:0] addr;
   logic          sram_we;
   logic [AW:0]   rec_len;
   logic [2:0]    state;
   logic [2:0]    ratio;
   logic          isNormalSpeed, interp, pause, isRecord;

   audio_transport_ctrl #(.ADDR_W(AW), .MAX_MAG(MAXM)) dut (
      .clk50(clk50), .reset(reset),
      .key_record(key_record), .key_play(key_play), .key_pause(key_pause),
      .key_stop(key_stop), .key_faster(key_faster), .key_slower(key_slower),
      .key_interp(key_interp), .sample_tick(sample_tick),
      .addr(addr), .sram_we(sram_we), .rec_len(rec_len), .state(state),
      .ratio(ratio), .isNormalSpeed(isNormalSpeed), .interp(interp),
      .pause(pause), .isRecord(isRecord)
   );

   always #10 clk50 = ~clk50;

   int n_vec = 0;
   int n_bad = 0;
   int wr_cnt = 0;

   int m_st, m_addr, m_len, m_s, m_tc;
   bit m_int;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_addr = 0; m_len = 0; m_s = 0; m_tc = 0; m_int = 1'b0;
   endtask

   // 0 none, 1 stop, 2 record, 3 play, 4 pause
   function automatic int pick(input bit [6:0] k);
      if (k[3] && m_st != M_IDLE) return 1;
      if (k[0] && (m_st == M_IDLE || m_st == M_RP)) return 2;
      if (k[1] && ((m_st == M_IDLE && m_len != 0) || m_st == M_PP)) return 3;
      if (k[2] && m_st != M_IDLE) return 4;
      return 0;
   endfunction

   task automatic commit(input bit rst, input bit [6:0] k, input bit tk);
      int key, ns, stp;
      key = pick(k);
      if (rst) begin
         model_reset();
         return;
      end
      m_int = m_int ^ k[6];
      if ((m_st == M_IDLE || m_st == M_PLAY || m_st == M_PP) && (k[4] ^ k[5])) begin
         if (k[4]) ns = (m_s < MAXM - 1) ? m_s + 1 : m_s;
         else      ns = (m_s > -(MAXM - 1)) ? m_s - 1 : m_s;
         if (ns != m_s) begin
            m_s  = ns;
            m_tc = 0;
         end
      end
      case (key)
         1: begin
            if (m_st == M_REC || m_st == M_RP) m_len = m_addr;
            m_st = M_IDLE; m_addr = 0;
         end
         2: begin
            if (m_st == M_IDLE) begin m_addr = 0; m_len = 0; end
            m_st = M_REC;
         end
         3: begin
            if (m_st == M_IDLE) begin m_addr = 0; m_tc = 0; end
            m_st = M_PLAY;
         end
         4: begin
            if (m_st == M_REC)       m_st = M_RP;
            else if (m_st == M_RP)   m_st = M_REC;
            else if (m_st == M_PLAY) m_st = M_PP;
            else                     m_st = M_PLAY;
         end
         default: begin
            if (tk && m_st == M_REC) begin
               if (m_addr == DEPTH - 1) begin
                  m_st = M_IDLE; m_len = DEPTH; m_addr = 0;
               end else begin
                  m_addr++;
               end
            end else if (tk && m_st == M_PLAY) begin
               if (m_s > 0) stp = m_s + 1;
               else if (m_s == 0) stp = 1;
               else begin
                  m_tc++;
                  if (m_tc == -m_s + 1) begin stp = 1; m_tc = 0; end
                  else stp = 0;
               end
               if (m_addr + stp >= m_len) begin
                  m_st = M_IDLE; m_addr = 0; m_tc = 0;
               end else begin
                  m_addr += stp;
               end
            end
         end
      endcase
   endtask

   task automatic step(input bit rst, input bit [6:0] k, input bit tk);
      bit exp_we;
      @(negedge clk50);
      reset       = rst;
      key_record  = k[0]; key_play   = k[1]; key_pause  = k[2]; key_stop = k[3];
      key_faster  = k[4]; key_slower = k[5]; key_interp = k[6];
      sample_tick = tk;
      #1;
      exp_we = !rst && m_st == M_REC && tk && pick(k) == 0;
      chk("sram_we", 32'(sram_we), 32'(exp_we));
      chk("state", 32'(state), m_st);
      chk("addr", 32'(addr), m_addr);
      chk("rec_len", 32'(rec_len), m_len);
      chk("ratio", 32'(ratio), (m_s < 0) ? -m_s : 0);
      chk("isNormalSpeed", 32'(isNormalSpeed), (m_s >= 0) ? 1 : 0);
      chk("interp", 32'(interp), 32'(m_int));
      chk("pause", 32'(pause), (m_st == M_IDLE || m_st == M_RP || m_st == M_PP) ? 1 : 0);
      chk("isRecord", 32'(isRecord), (m_st == M_REC || m_st == M_RP) ? 1 : 0);
      if (sram_we === 1'b1) wr_cnt++;
      @(posedge clk50);
      commit(rst, k, tk);
   endtask

   initial begin
      bit [6:0] k;
      bit       tk, rst;
      reset = 1'b1;
      {key_record, key_play, key_pause, key_stop} = '0;
      {key_faster, key_slower, key_interp, sample_tick} = '0;
      repeat (2) @(posedge clk50);
      model_reset();
      step(1'b1, '0, 1'b1);

      // reset values
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_ratio", 32'(ratio), 0);
      chk("rst_norm", 32'(isNormalSpeed), 1);
      chk("rst_we", 32'(sram_we), 0);

      // record five samples then stop
      wr_cnt = 0;
      step(1'b0, K_REC, 1'b0);
      repeat (5) step(1'b0, '0, 1'b1);
      step(1'b0, K_STOP, 1'b0);
      #1;
      chk("rec5_writes", wr_cnt, 5);
      chk("rec5_len", 32'(rec_len), 5);
      chk("rec5_state", 32'(state), 0);

      // normal playback runs to the end
      step(1'b0, K_PLAY, 1'b0);
      repeat (4) step(1'b0, '0, 1'b1);
      #1 chk("play_last_addr", 32'(addr), 4);
      step(1'b0, '0, 1'b1);
      #1 chk("play_end_state", 32'(state), 0);

      // fast x3 playback of a ten-sample recording
      step(1'b0, K_REC, 1'b0);
      repeat (10) step(1'b0, '0, 1'b1);
      step(1'b0, K_STOP, 1'b0);
      repeat (2) step(1'b0, K_FAST, 1'b0);
      step(1'b0, K_PLAY, 1'b0);
      repeat (3) step(1'b0, '0, 1'b1);
      #1;
      chk("fast_addr", 32'(addr), 9);
      chk("fast_ratio", 32'(ratio), 0);
      chk("fast_norm", 32'(isNormalSpeed), 1);
      step(1'b0, '0, 1'b1);
      #1 chk("fast_end_state", 32'(state), 0);

      // slow x4: fast3 -> fast2 -> normal -> slow2 -> slow3 -> slow4
      repeat (5) step(1'b0, K_SLOW, 1'b0);
      #1;
      chk("slow_ratio", 32'(ratio), 3);
      chk("slow_norm", 32'(isNormalSpeed), 0);
      step(1'b0, K_PLAY, 1'b0);
      repeat (3) step(1'b0, '0, 1'b1);
      #1 chk("slow_hold", 32'(addr), 0);
      step(1'b0, '0, 1'b1);
      #1 chk("slow_adv", 32'(addr), 1);
      step(1'b0, K_STOP, 1'b0);

      // faster twelve times saturates at fast x8
      repeat (12) step(1'b0, K_FAST, 1'b0);
      step(1'b0, K_PLAY, 1'b0);
      step(1'b0, '0, 1'b1);
      #1 chk("sat_addr", 32'(addr), 8);
      step(1'b0, K_STOP, 1'b0);

      // record pause/resume and a pause that swallows a tick
      step(1'b0, K_REC, 1'b0);
      repeat (2) step(1'b0, '0, 1'b1);
      step(1'b0, K_PAUS, 1'b0);
      step(1'b0, '0, 1'b1);
      #1 chk("rpause_addr", 32'(addr), 2);
      step(1'b0, K_PAUS, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, K_PAUS, 1'b1);
      #1;
      chk("pause_tick_addr", 32'(addr), 3);
      chk("pause_tick_state", 32'(state), 2);
      step(1'b0, K_STOP, 1'b0);

      // fill the whole memory
      wr_cnt = 0;
      step(1'b0, K_REC | K_INT, 1'b0);
      repeat (DEPTH) step(1'b0, '0, 1'b1);
      #1;
      chk("full_writes", wr_cnt, DEPTH);
      chk("full_len", 32'(rec_len), DEPTH);
      chk("full_state", 32'(state), 0);

      // play after reset has nothing to play
      step(1'b1, '0, 1'b0);
      step(1'b0, K_PLAY, 1'b0);
      #1 chk("play_empty_state", 32'(state), 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         k  = '0;
         tk = ($urandom_range(0, 9) < 4);
         k[0] = ($urandom_range(0, 19) == 0);
         k[1] = ($urandom_range(0, 14) == 0);
         k[2] = ($urandom_range(0, 24) == 0);
         k[3] = ($urandom_range(0, 59) == 0);
         if (!tk) begin
            k[4] = ($urandom_range(0, 29) == 0);
            k[5] = ($urandom_range(0, 29) == 0);
         end
         k[6] = ($urandom_range(0, 39) == 0);
         rst  = ($urandom_range(0, 499) == 0);
         step(rst, k, tk);
      end
      step(1'b0, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
